mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter WAIT_MEM, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  input  6  opcode field of the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have outputs memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, branch, pcwrite, pcen, each 1 bit: datapath controls.
REQ-008 SHALL have outputs alusrcb  output  2, pcsrc  output  2, aluop  output  2: datapath mux/ALU selects.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have port retired  output  16  count of completed instructions.
REQ-011 SHALL have port state_dbg  output  4  current state code.

Function
REQ-012 SHALL implement a Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-014 DECODE SHALL branch on op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; any other op -> FETCH with illegal=1 for that cycle.
REQ-015 MEMADR SHALL go to MEMRD on op=100011 and to MEMWR otherwise.
REQ-016 MEMRD SHALL hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWR SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 EXECUTE->ALUWB and ADDIEXEC->ADDIWB SHALL be unconditional; MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL go to FETCH unconditionally.
REQ-019 Outputs not listed for a state SHALL be 0.
REQ-020 FETCH SHALL drive alusrcb=01, with irwrite=pcwrite=mem_ready (gated).
REQ-021 DECODE SHALL drive alusrcb=11.
REQ-022 MEMADR and ADDIEXEC SHALL drive alusrca=1, alusrcb=10.
REQ-023 MEMRD SHALL drive iord=1.
REQ-024 MEMWB SHALL drive memtoreg=1, regwrite=1.
REQ-025 MEMWR SHALL drive iord=1 and memwrite=1 for every waiting cycle.
REQ-026 EXECUTE SHALL drive alusrca=1, aluop=10.
REQ-027 ALUWB SHALL drive regdst=1, regwrite=1.
REQ-028 ADDIWB SHALL drive regwrite=1.
REQ-029 BRANCH SHALL drive alusrca=1, aluop=01, pcsrc=01, branch=1.
REQ-030 JUMP SHALL drive pcsrc=10, pcwrite=1.
REQ-031 pcen SHALL equal pcwrite OR (branch AND zero), combinationally.
REQ-032 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP; it SHALL wrap from 0xFFFF to 0x0000 and SHALL NOT increment on the illegal DECODE->FETCH path.
REQ-033 With WAIT_MEM=0, FETCH, MEMRD and MEMWR SHALL each last exactly one cycle.

Reset
REQ-034 reset=1 SHALL force state=FETCH, retired=0 and illegal=0 immediately, independent of clk.
REQ-035 During and after reset, outputs SHALL follow the FETCH row; irwrite/pcwrite SHALL remain gated by mem_ready and SHALL be 0 while reset=1.
REQ-036 Reset asserted mid-instruction, including in MEMWR with memwrite=1, SHALL drop memwrite the same cycle and SHALL NOT increment retired.

Verification
REQ-037 WAIT_MEM=0, lw (100011): state sequence 0,1,2,3,4,0; regwrite and memtoreg are 1 only in state 4; retired goes 0->1.
REQ-038 sw with mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles; leaves on ready; retired +1.
REQ-039 beq with zero=1 in BRANCH: pcen=1, pcsrc=01; with zero=0: pcen=0; both take 3 cycles and retire.
REQ-040 op=111111 in DECODE: illegal pulses for 1 cycle; next state is FETCH; retired unchanged.
REQ-041 Preload retired=0xFFFF via 65535 j instructions, then one more: retired=0x0000.
REQ-042 Assert reset asynchronously while in ALUWB: state_dbg=0 and regwrite=0 before the next clk edge.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style main controller: Moore FSM with registered control outputs,
// memory-ready handshaking, illegal-opcode pulse and a retired-instruction counter.
module mc_controller #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        alusrca,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic        branch,
    output logic        pcwrite,
    output logic        pcen,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [1:0]  aluop,
    output logic        illegal,
    output logic [15:0] retired,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       jump;
        logic       memwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       branch;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    state_t      state_q, state_d;
    ctrl_t       ctrl_q;
    logic        illegal_q, illegal_d;
    logic        retire_d;
    logic [15:0] retired_q;
    logic        ready;

    assign ready = WAIT_MEM ? mem_ready : 1'b1;

    // Control row for a state; registered from the next state so outputs track state_q.
    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:   c.alusrcb = 2'b11;
            S_MEMADR,
            S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_BRANCH:   begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_JUMP:     begin c.pcsrc = 2'b10; c.jump = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        retire_d  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    6'b100011,
                    6'b101011: state_d = S_MEMADR;
                    6'b000000: state_d = S_EXECUTE;
                    6'b000100: state_d = S_BRANCH;
                    6'b001000: state_d = S_ADDIEXEC;
                    6'b000010: state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d  = ready ? S_FETCH : S_MEMWR;
                retire_d = ready;
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode(S_FETCH);
            illegal_q <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode(state_d);
            illegal_q <= illegal_d;
            if (retire_d) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // Fetch-side writes wait for the memory and are held off while reset is asserted.
    assign irwrite   = ctrl_q.fetch & ready & ~reset;
    assign pcwrite   = irwrite | ctrl_q.jump;
    assign pcen      = pcwrite | (ctrl_q.branch & zero);
    assign memwrite  = ctrl_q.memwrite;
    assign regwrite  = ctrl_q.regwrite;
    assign alusrca   = ctrl_q.alusrca;
    assign iord      = ctrl_q.iord;
    assign memtoreg  = ctrl_q.memtoreg;
    assign regdst    = ctrl_q.regdst;
    assign branch    = ctrl_q.branch;
    assign alusrcb   = ctrl_q.alusrcb;
    assign pcsrc     = ctrl_q.pcsrc;
    assign aluop     = ctrl_q.aluop;
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule
